reg_file_flags: RTL and testbench

Architectural register file and status-flag store for the 8-bit datapath. It sits directly upstream and downstream of the ALU:
- its two read ports drive the ALU `inA`/`inB` operands;
- its write port and flag latches capture the ALU `rslt`, `sc_o`, `zero` and `pari` outputs.

The held shift-carry is fed back to the ALU `sc_i`, which makes multi-byte add, subtract and shift chains span instructions. Write-through bypass lets an instruction read a value in the same cycle it is written.

---
 rtl/reg_file_flags.sv | 78 +++++++
 tb/tb_reg_file_flags.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_flags.sv
// Architectural register file with write-through bypass, plus the ALU status-flag
// store (shift-carry, zero, parity) that feeds carry back into multi-byte chains.
module reg_file_flags #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [W-1:0]  rd_a,
  output logic [W-1:0]  rd_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          flag_we,
  input  logic          sc_clr,
  input  logic          sc_in,
  input  logic          zero_in,
  input  logic          pari_in,
  output logic          sc_q,
  output logic          zero_q,
  output logic          pari_q
);

  localparam int NREG = 2 ** AW;

  logic [W-1:0] regs_r [NREG];
  logic         hit_a_s;
  logic         hit_b_s;

  // Register storage: cleared asynchronously, one write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Flag store: reset matches an all-zero result; carry clear outranks a flag load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q   <= 1'b0;
      zero_q <= 1'b1;
      pari_q <= 1'b0;
    end else begin
      if (sc_clr) begin
        sc_q <= 1'b0;
      end else if (flag_we) begin
        sc_q <= sc_in;
      end
      if (flag_we) begin
        zero_q <= zero_in;
        pari_q <= pari_in;
      end
    end
  end

  // Read ports: a single 2:1 bypass mux per port keeps wr_data -> ALU operand short.
  always_comb begin
    hit_a_s = wr_en && (rd_addr_a == wr_addr);
    hit_b_s = wr_en && (rd_addr_b == wr_addr);
    if (hit_a_s) begin
      rd_a = wr_data;
    end else begin
      rd_a = regs_r[rd_addr_a];
    end
    if (hit_b_s) begin
      rd_b = wr_data;
    end else begin
      rd_b = regs_r[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_reg_file_flags.sv
// Scoreboard bench for reg_file_flags: directed scenarios followed by random traffic,
// checked against an array-based reference model of the register file and flags.
module tb_reg_file_flags;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sc;
    logic       z;
    logic       p;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] rd_a, rd_b, wr_data;
  logic       wr_en, flag_we, sc_clr, sc_in, zero_in, pari_in;
  logic       sc_q, zero_q, pari_q;

  logic [7:0] m_mem [8];
  logic       m_sc, m_zero, m_pari;
  exp_t       sb_q [$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;

  reg_file_flags #(.W(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_a(rd_a), .rd_b(rd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .sc_clr(sc_clr), .sc_in(sc_in),
    .zero_in(zero_in), .pari_in(pari_in),
    .sc_q(sc_q), .zero_q(zero_q), .pari_q(pari_q)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      cmp("rd_a",   rd_a,          mon_e.a);
      cmp("rd_b",   rd_b,          mon_e.b);
      cmp("sc_q",   {7'd0, sc_q},   {7'd0, mon_e.sc});
      cmp("zero_q", {7'd0, zero_q}, {7'd0, mon_e.z});
      cmp("pari_q", {7'd0, pari_q}, {7'd0, mon_e.p});
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_sc   = 1'b0;
    m_zero = 1'b1;
    m_pari = 1'b0;
  endtask

  // Expected outputs for the inputs currently applied.
  task automatic check_now();
    exp_t e;
    e.a  = (wr_en && rd_addr_a == wr_addr) ? wr_data : m_mem[rd_addr_a];
    e.b  = (wr_en && rd_addr_b == wr_addr) ? wr_data : m_mem[rd_addr_b];
    e.sc = m_sc;
    e.z  = m_zero;
    e.p  = m_pari;
    sb_q.push_back(e);
  endtask

  // Advance one rising edge and apply the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (sc_clr) m_sc = 1'b0;
      else if (flag_we) m_sc = sc_in;
      if (flag_we) begin
        m_zero = zero_in;
        m_pari = pari_in;
      end
    end
    #1;
  endtask

  task automatic cycle();
    check_now();
    tick();
  endtask

  task automatic set_in(input logic [2:0] a, input logic [2:0] b, input logic we,
                        input logic [2:0] wa, input logic [7:0] wd, input logic fwe,
                        input logic clr, input logic sc, input logic z, input logic p);
    rd_addr_a = a; rd_addr_b = b; wr_en = we; wr_addr = wa; wr_data = wd;
    flag_we = fwe; sc_clr = clr; sc_in = sc; zero_in = z; pari_in = p;
  endtask

  // Reset pulse strictly between edges; checked before the next rising edge.
  task automatic reset_pulse();
    #1;
    rst_n = 1'b0;
    model_reset();
    check_now();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    // Reset asserted with no clock edge yet, then all 8 addresses read.
    #1;
    rst_n = 1'b0;
    cycle();
    set_in(3'd2, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd4, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd6, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    // Writes and flag loads while reset is held are ignored; bypass still works.
    set_in(3'd4, 3'd1, 1'b1, 3'd4, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); cycle();
    set_in(3'd4, 3'd1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    cycle();

    // Write/read.
    set_in(3'd0, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd0, 3'd0, 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd3, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 8; i += 2) begin
      set_in(3'(i), 3'(i + 1), 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
    end

    // Bypass on both ports to the same address.
    set_in(3'd2, 3'd2, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd2, 3'd2, 1'b1, 3'd2, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd2, 3'd2, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();

    // Carry chain.
    set_in(3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
    set_in(3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    cycle();

    // Clear versus load at the same edge.
    set_in(3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cycle();
    set_in(3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();

    // Reset in the middle of a chain.
    set_in(3'd7, 3'd0, 1'b1, 3'd7, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    set_in(3'd7, 3'd0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    reset_pulse();
    set_in(3'd7, 3'd0, 1'b1, 3'd7, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(3'd7, 3'd0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom_range(0, 255));
      flag_we   = 1'($urandom_range(0, 1));
      sc_clr    = ($urandom_range(0, 5) == 0);
      sc_in     = 1'($urandom_range(0, 1));
      zero_in   = 1'($urandom_range(0, 1));
      pari_in   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse();
      end else begin
        cycle();
      end
    end

    @(negedge clk);
    #1;
    cmp("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
